// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: scatters a streamed job round-robin to NUM_PE PEs, kicks them, waits for all EOC.
// Ports: ACLK/ARESETN clock and async active-low reset; cfg_* job descriptor handshake;
// s_* input data stream; pe_data/CTRL_PE registered PE write bus {pe_id, valid, namespace};
// START compute pulse; EOC per-PE end-of-compute; busy/done/err status.
// Optional: define PE_LOAD_WATCHDOG_EN to abort WAIT after 1024 cycles with a sticky err.
module pe_load_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_PE          = 4,
  parameter int PE_ID_WIDTH     = 2,
  parameter int NAMESPACE_WIDTH = 2,
  parameter int COUNT_WIDTH     = 8,
  parameter int CTRL_PE_WIDTH   = PE_ID_WIDTH + 1 + NAMESPACE_WIDTH
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [NAMESPACE_WIDTH-1:0] cfg_namespace,
  input  logic [COUNT_WIDTH-1:0]     cfg_words_per_pe,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      pe_data,
  output logic [CTRL_PE_WIDTH-1:0]   CTRL_PE,
  output logic                       START,
  input  logic [NUM_PE-1:0]          EOC,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, KICK = 3'd2, WAIT = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [NAMESPACE_WIDTH-1:0] ns;
  logic [COUNT_WIDTH-1:0] wpp, word_cnt;
  logic [PE_ID_WIDTH-1:0] pe_idx;
  logic [NUM_PE-1:0] eoc_seen;
  logic beat, wrap, last, all_eoc, wdog_hit;
  assign cfg_ready = state == IDLE;
  assign s_ready   = state == LOAD;
  assign START     = state == KICK;
  assign done      = state == DONE;
  assign busy      = state != IDLE;
  assign beat      = s_valid && s_ready;
  assign wrap      = pe_idx == PE_ID_WIDTH'(NUM_PE - 1);
  assign last      = beat && wrap && word_cnt == wpp - COUNT_WIDTH'(1);
  // EOC arriving this cycle counts immediately so a single-cycle pulse is never lost
  assign all_eoc   = &(eoc_seen | EOC);
`ifdef PE_LOAD_WATCHDOG_EN
  localparam int WDOG_CYCLES = 1024;
  logic [$clog2(WDOG_CYCLES)-1:0] wdog;
  assign wdog_hit = wdog == $clog2(WDOG_CYCLES)'(WDOG_CYCLES - 1);
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      wdog <= state == WAIT ? wdog + 1'b1 : '0;
      if (state == WAIT && wdog_hit && !all_eoc) err <= 1'b1;
    end
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state    <= IDLE;
      ns       <= '0;
      wpp      <= '0;
      word_cnt <= '0;
      pe_idx   <= '0;
      eoc_seen <= '0;
      pe_data  <= '0;
      CTRL_PE  <= '0;
    end else begin
      if (beat) begin
        pe_data <= s_data;
        CTRL_PE <= {pe_idx, 1'b1, ns};
      end else
        CTRL_PE[NAMESPACE_WIDTH] <= 1'b0;
      case (state)
        IDLE: if (cfg_valid) begin
          ns       <= cfg_namespace;
          wpp      <= cfg_words_per_pe;
          pe_idx   <= '0;
          word_cnt <= '0;
          eoc_seen <= '0;
          state    <= cfg_words_per_pe == '0 ? KICK : LOAD;
        end
        LOAD: if (beat) begin
          pe_idx <= wrap ? '0 : pe_idx + 1'b1;
          if (wrap) word_cnt <= word_cnt + 1'b1;
          if (last) state <= KICK;
        end
        KICK: state <= WAIT;
        WAIT: begin
          eoc_seen <= eoc_seen | EOC;
          if (all_eoc || wdog_hit) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
